// File: rtl/fetch.sv
// Instruction fetch unit: owns the program counter, fetches instruction
// words from program memory over a req/ack handshake and presents them to
// control through Ir/OpCode/InstrValid, honouring PcWait stalls and
// relative branches.
// Optional feature: define FETCH_HALT_EN to stop the core on an all-ones
// opcode (HALT state, left only by reset). Without it Halted is tied low.
module fetch #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int OP_WIDTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic                   MemReq,
  output logic [PC_WIDTH-1:0]    MemAddr,
  input  logic                   MemAck,
  input  logic [INSTR_WIDTH-1:0] MemData,
  output logic [INSTR_WIDTH-1:0] Ir,
  output logic [OP_WIDTH-1:0]    OpCode,
  output logic                   InstrValid,
  input  logic                   PcWait,
  input  logic                   Branch,
  output logic [PC_WIDTH-1:0]    Pc,
  output logic                   Halted
);

  // HALT is only ever entered when FETCH_HALT_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } stateT;

  stateT state;
  stateT nextState;
  logic  advancePc;

  // The branch offset is the low PC_WIDTH bits of Ir; sign-extending it to
  // PC_WIDTH is the identity, and the add wraps modulo 2^PC_WIDTH.
  logic [PC_WIDTH-1:0] branchOffset;
  logic [PC_WIDTH-1:0] branchTarget;
  logic [PC_WIDTH-1:0] seqTarget;

  assign branchOffset = PC_WIDTH'($signed(Ir[PC_WIDTH-1:0]));
  assign branchTarget = Pc + branchOffset;
  assign seqTarget    = Pc + PC_WIDTH'(1);

  assign OpCode  = Ir[INSTR_WIDTH-1 -: OP_WIDTH];
  assign MemReq  = (state == FETCH);
  assign MemAddr = Pc;

`ifdef FETCH_HALT_EN
  logic isHaltOp;
  assign isHaltOp = &OpCode;
  assign Halted   = (state == HALT);
`else
  assign Halted   = 1'b0;
`endif

  // Next-state decode; advancePc marks the ISSUE edge that moves the PC on.
  always_comb begin
    nextState = state;
    advancePc = 1'b0;
    case (state)
      IDLE: begin
        nextState = FETCH;
      end
      FETCH: begin
        if (MemAck) begin
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        if (!PcWait) begin
`ifdef FETCH_HALT_EN
          if (isHaltOp) begin
            nextState = HALT;
          end else begin
            nextState = FETCH;
            advancePc = 1'b1;
          end
`else
          nextState = FETCH;
          advancePc = 1'b1;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        nextState = HALT;
      end
`endif
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register; reset abandons any fetch in flight and drops MemReq.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Instruction register, valid flag and program counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Pc         <= RESET_PC;
      Ir         <= '0;
      InstrValid <= 1'b0;
    end else begin
      if (state == FETCH && MemAck) begin
        Ir         <= MemData;
        InstrValid <= 1'b1;
      end
      if (state == ISSUE && !PcWait) begin
        InstrValid <= 1'b0;
      end
      if (advancePc) begin
        Pc <= Branch ? branchTarget : seqTarget;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Testbench for fetch: directed scenarios with literal expectations, then
// randomized memory latency, stalls and branches, all compared every cycle
// against a behavioural model of the fetch unit.
module tb_fetch;

  logic        Clock;
  logic        Reset;
  logic        MemReq;
  logic [7:0]  MemAddr;
  logic        MemAck;
  logic [15:0] MemData;
  logic [15:0] Ir;
  logic [3:0]  OpCode;
  logic        InstrValid;
  logic        PcWait;
  logic        Branch;
  logic [7:0]  Pc;
  logic        Halted;

  int tests    = 0;
  int failures = 0;
  bit checkEn  = 0;

  fetch #(
    .PC_WIDTH(8),
    .INSTR_WIDTH(16),
    .OP_WIDTH(4),
    .RESET_PC(8'h00)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .MemReq(MemReq),
    .MemAddr(MemAddr),
    .MemAck(MemAck),
    .MemData(MemData),
    .Ir(Ir),
    .OpCode(OpCode),
    .InstrValid(InstrValid),
    .PcWait(PcWait),
    .Branch(Branch),
    .Pc(Pc),
    .Halted(Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural model: what the fetch unit must hold after each edge.
  logic [7:0]  mPc;
  logic [15:0] mIr;
  bit          mValid;
  bit          mStarted;
  bit          mHalted;

  function automatic bit modelFetching();
    return mStarted && !mValid && !mHalted;
  endfunction

  always @(posedge Clock or negedge Reset) begin
    int off;
    if (!Reset) begin
      mPc = 8'h00; mIr = 16'h0000; mValid = 0; mStarted = 0; mHalted = 0;
    end else if (!mStarted) begin
      mStarted = 1;
    end else if (mHalted) begin
      mHalted = 1;
    end else if (!mValid) begin
      if (MemAck) begin
        mIr = MemData;
        mValid = 1;
      end
    end else if (!PcWait) begin
      mValid = 0;
`ifdef FETCH_HALT_EN
      if (mIr[15:12] == 4'hF) begin
        mHalted = 1;
      end else
`endif
      begin
        if (Branch) begin
          off = int'(mIr[7:0]);
          if (off >= 128) off = off - 256;
        end else begin
          off = 1;
        end
        mPc = 8'((int'(mPc) + off + 256) % 256);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    if (checkEn) begin
      checkOutput("cmpMemReq", 32'(MemReq), 32'(modelFetching()));
      checkOutput("cmpMemAddr", 32'(MemAddr), 32'(mPc));
      checkOutput("cmpPc", 32'(Pc), 32'(mPc));
      checkOutput("cmpIr", 32'(Ir), 32'(mIr));
      checkOutput("cmpOpCode", 32'(OpCode), 32'(mIr[15:12]));
      checkOutput("cmpInstrValid", 32'(InstrValid), 32'(mValid));
      checkOutput("cmpHalted", 32'(Halted), 32'(mHalted));
    end
  end

  task automatic applyStimulus(input logic ack, input logic [15:0] data, input logic pw, input logic br);
    MemAck  = ack;
    MemData = data;
    PcWait  = pw;
    Branch  = br;
    @(posedge Clock);
    #1;
  endtask

  logic [15:0] mem [256];

  initial begin
    int waitLeft;
    logic ack;
    logic [15:0] data;
    logic pw;
    logic br;

    Reset = 1'b0; MemAck = 0; MemData = 0; PcWait = 0; Branch = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'hE;
    end
    repeat (3) @(posedge Clock);
    #1;
    checkEn = 1;
    checkOutput("rstMemReq", 32'(MemReq), 32'h0);
    checkOutput("rstPc", 32'(Pc), 32'h00);
    checkOutput("rstIr", 32'(Ir), 32'h0000);
    checkOutput("rstInstrValid", 32'(InstrValid), 32'h0);
    checkOutput("rstHalted", 32'(Halted), 32'h0);
    Reset = 1'b1;

    // One IDLE cycle, then a zero-wait fetch of 16'h1000 at address 0.
    applyStimulus(0, 16'h0000, 0, 0);
    checkOutput("firstReq", 32'(MemReq), 32'h1);
    checkOutput("firstAddr", 32'(MemAddr), 32'h00);
    applyStimulus(1, 16'h1000, 0, 0);
    checkOutput("firstIr", 32'(Ir), 32'h1000);
    checkOutput("firstOpCode", 32'(OpCode), 32'h1);
    checkOutput("firstValid", 32'(InstrValid), 32'h1);
    checkOutput("issueNoReq", 32'(MemReq), 32'h0);
    applyStimulus(0, 16'h0000, 0, 0);
    checkOutput("nextAddr", 32'(MemAddr), 32'h01);
    checkOutput("nextReq", 32'(MemReq), 32'h1);

    // Three memory wait cycles: request held stable, nothing valid yet.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 16'h0000, 0, 0);
      checkOutput("waitReq", 32'(MemReq), 32'h1);
      checkOutput("waitAddr", 32'(MemAddr), 32'h01);
      checkOutput("waitValid", 32'(InstrValid), 32'h0);
    end
    applyStimulus(1, 16'h200F, 0, 0);
    checkOutput("ackIr", 32'(Ir), 32'h200F);
    checkOutput("ackValid", 32'(InstrValid), 32'h1);

    // Five stalled ISSUE cycles with a spurious ack and a pending branch.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 16'hBEEF, 1, 1);
      checkOutput("stallIr", 32'(Ir), 32'h200F);
      checkOutput("stallPc", 32'(Pc), 32'h01);
      checkOutput("stallValid", 32'(InstrValid), 32'h1);
    end
    applyStimulus(0, 16'h0000, 0, 1);
    checkOutput("branchFwd", 32'(MemAddr), 32'h10);

    // Backward branch from 8'h10 by -4.
    applyStimulus(1, 16'h20FC, 0, 0);
    checkOutput("bwdOpCode", 32'(OpCode), 32'h2);
    applyStimulus(0, 16'h0000, 0, 1);
    checkOutput("branchBwd", 32'(MemAddr), 32'h0C);

    // Branch to 8'hFF, then sequential wrap to 8'h00.
    applyStimulus(1, 16'h30F3, 0, 0);
    applyStimulus(0, 16'h0000, 0, 1);
    checkOutput("toFF", 32'(MemAddr), 32'hFF);
    applyStimulus(1, 16'h4000, 0, 0);
    applyStimulus(0, 16'h0000, 0, 0);
    checkOutput("wrap", 32'(MemAddr), 32'h00);

    // Randomized latency, stalls, branches and spurious acks.
    waitLeft = 0;
    for (int c = 0; c < 2000; c++) begin
      if (modelFetching()) begin
        if (waitLeft == 0) begin
          ack = 1; data = mem[mPc]; waitLeft = int'($urandom_range(0, 3));
        end else begin
          ack = 0; data = 16'($urandom); waitLeft--;
        end
      end else begin
        ack = ($urandom_range(0, 3) == 0); data = 16'($urandom);
      end
      pw = ($urandom_range(0, 9) < 3);
      br = 1'($urandom_range(0, 1));
      applyStimulus(ack, data, pw, br);
    end

    // Reset in the middle of a fetch wait.
    for (int k = 0; k < 20 && !modelFetching(); k++) applyStimulus(0, 16'h0000, 0, 0);
    tests++;
    if (!modelFetching()) begin
      failures++;
      $display("[TB] FAIL reachFetch: got no fetch, expected fetch within 20 cycles");
    end
    applyStimulus(0, 16'h0000, 0, 0);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("midRstMemReq", 32'(MemReq), 32'h0);
    checkOutput("midRstPc", 32'(Pc), 32'h00);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    checkOutput("restartIdle", 32'(MemReq), 32'h0);
    applyStimulus(0, 16'h0000, 0, 0);
    checkOutput("restartReq", 32'(MemReq), 32'h1);
    checkOutput("restartAddr", 32'(MemAddr), 32'h00);

    // All-ones opcode.
    applyStimulus(1, 16'hF000, 0, 0);
    applyStimulus(0, 16'h0000, 0, 0);
`ifdef FETCH_HALT_EN
    checkOutput("haltHalted", 32'(Halted), 32'h1);
    checkOutput("haltReq", 32'(MemReq), 32'h0);
    checkOutput("haltPc", 32'(Pc), 32'h00);
    checkOutput("haltValid", 32'(InstrValid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'h1234, 0, 1);
      checkOutput("haltStayReq", 32'(MemReq), 32'h0);
      checkOutput("haltStayPc", 32'(Pc), 32'h00);
    end
`else
    checkOutput("noHaltHalted", 32'(Halted), 32'h0);
    checkOutput("noHaltPc", 32'(Pc), 32'h01);
    checkOutput("noHaltReq", 32'(MemReq), 32'h1);
`endif
    applyStimulus(0, 16'h0000, 0, 0);

    checkEn = 0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
